// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the transmit path, which
// uses the same baud divisor function so TxD can loop straight into RxD).
//   - rx_state_e      : receiver FSM states
//   - baud_divisor()  : round(clk_freq / (16 * baud)) for a 3-bit rate select
//   - OVERSAMPLE, MID_SAMPLE, DATA_BITS, DIV_WIDTH constants
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;
  localparam int DIV_WIDTH  = 15;
  localparam int DIV_MAX    = (1 << DIV_WIDTH) - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Rate select: 000=300 ... 111=115200 baud. Result is rounded to nearest
  // and clamped into the divisor counter range.
  function automatic logic [DIV_WIDTH-1:0] baud_divisor(input logic [2:0] sel,
                                                        input int clk_freq);
    int baud;
    int div;
    case (sel)
      3'd0:    baud = 300;
      3'd1:    baud = 1200;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    div = (clk_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    if (div < 1) begin
      div = 1;
    end else if (div > DIV_MAX) begin
      div = DIV_MAX;
    end
    return div[DIV_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_rx_baud_gen
// Divides the system clock down to the 16x oversampling tick. The counter is
// held at zero while clear_i is high, so the first tick after clear_i drops
// arrives exactly div_i clocks later, aligning tick phase to the start edge.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   clear_i  in   hold counter at zero, suppress tick
//   div_i    in   divisor (clocks per tick), 15 bits
//   tick_o   out  one-clock pulse every div_i clocks
// -----------------------------------------------------------------------------
module uart_rx_baud_gen
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;
  logic                 atEnd;

  assign atEnd  = (count_q == div_i - {{(DIV_WIDTH-1){1'b0}}, 1'b1});
  assign tick_o = !clear_i && atEnd;

  // Next count: restart on clear or at the end of each tick period.
  always_comb begin
    count_d = count_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    if (clear_i || atEnd) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Receive half of the UART: deserialises 8-bit frames from RxD with 16x
// oversampling. Good bytes appear on Rx_DATA with a one-clock Rx_VALID strobe;
// bad stop bits pulse Rx_FERROR and parity mismatches pulse Rx_PERROR.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (adds the PARITY
// state); otherwise frames are 8N1 and Rx_PERROR is tied low.
// Ports:
//   clk          in   system clock (rising edge)
//   reset        in   asynchronous active-low reset
//   baud_select  in   3-bit rate select (000=300 ... 111=115200)
//   Rx_EN        in   receiver enable; low aborts and holds IDLE
//   RxD          in   asynchronous serial input, idles high
//   Rx_DATA      out  last good byte
//   Rx_VALID     out  one-clock good-frame strobe
//   Rx_FERROR    out  one-clock framing-error strobe
//   Rx_PERROR    out  one-clock parity-error strobe
//   Rx_BUSY      out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR,
  output logic       Rx_BUSY
);

  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [1:0]           sync_q;
  logic [3:0]           tickCount_q;
  logic [2:0]           bitCount_q;
  logic [7:0]           shiftReg_q;
  logic [DIV_WIDTH-1:0] divLatched_q;
  logic [DIV_WIDTH-1:0] divSelect;
  logic [7:0]           rxData_q;
  logic                 rxValid_q;
  logic                 rxFerror_q;
  logic                 lineSync;
  logic                 baudTick;
  logic                 baudClear;
`ifdef UART_RX_PARITY_EN
  logic                 parityBad_q;
  logic                 rxPerror_q;
`endif

  // Two-flop synchroniser; both stages reset to the idle line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RxD};
    end
  end

  assign lineSync = sync_q[1];

  // Divisor lookup; every call has constant arguments so this is a constant mux.
  always_comb begin
    divSelect = baud_divisor(3'd7, CLK_FREQ);
    case (baud_select)
      3'd0: divSelect = baud_divisor(3'd0, CLK_FREQ);
      3'd1: divSelect = baud_divisor(3'd1, CLK_FREQ);
      3'd2: divSelect = baud_divisor(3'd2, CLK_FREQ);
      3'd3: divSelect = baud_divisor(3'd3, CLK_FREQ);
      3'd4: divSelect = baud_divisor(3'd4, CLK_FREQ);
      3'd5: divSelect = baud_divisor(3'd5, CLK_FREQ);
      3'd6: divSelect = baud_divisor(3'd6, CLK_FREQ);
      3'd7: divSelect = baud_divisor(3'd7, CLK_FREQ);
      default: divSelect = baud_divisor(3'd7, CLK_FREQ);
    endcase
  end

  // Holding the tick generator clear through IDLE means it restarts on the
  // very edge that detects the start bit.
  assign baudClear = (state_q == IDLE) || !Rx_EN;

  uart_rx_baud_gen u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .clear_i (baudClear),
    .div_i   (divLatched_q),
    .tick_o  (baudTick)
  );

  // Receiver FSM with registered strobes. Strobes default low every cycle so
  // each one lasts exactly one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tickCount_q  <= '0;
      bitCount_q   <= '0;
      shiftReg_q   <= '0;
      divLatched_q <= baud_divisor(3'd7, CLK_FREQ);
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      rxFerror_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBad_q  <= 1'b0;
      rxPerror_q   <= 1'b0;
`endif
    end else begin
      rxValid_q  <= 1'b0;
      rxFerror_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rxPerror_q <= 1'b0;
`endif
      if (!Rx_EN) begin
        state_q     <= IDLE;
        tickCount_q <= '0;
        bitCount_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!lineSync) begin
              divLatched_q <= divSelect;
              tickCount_q  <= '0;
              bitCount_q   <= '0;
              state_q      <= START;
            end
          end
          // Re-check the line half a bit in to reject glitches.
          START: begin
            if (baudTick) begin
              if (tickCount_q == TICK_MID) begin
                tickCount_q <= '0;
                state_q     <= lineSync ? IDLE : DATA;
              end else begin
                tickCount_q <= tickCount_q + 4'd1;
              end
            end
          end
          DATA: begin
            if (baudTick) begin
              tickCount_q <= tickCount_q + 4'd1;
              if (tickCount_q == TICK_LAST) begin
                shiftReg_q <= {lineSync, shiftReg_q[7:1]};
                bitCount_q <= bitCount_q + 3'd1;
                if (bitCount_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_q <= PARITY;
`else
                  state_q <= STOP;
`endif
                end
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          // Even parity: data plus parity bit must XOR to zero.
          PARITY: begin
            if (baudTick) begin
              tickCount_q <= tickCount_q + 4'd1;
              if (tickCount_q == TICK_LAST) begin
                parityBad_q <= ^{shiftReg_q, lineSync};
                state_q     <= STOP;
              end
            end
          end
`endif
          // Framing error outranks parity error; one strobe per frame.
          STOP: begin
            if (baudTick) begin
              tickCount_q <= tickCount_q + 4'd1;
              if (tickCount_q == TICK_LAST) begin
                if (!lineSync) begin
                  rxFerror_q <= 1'b1;
                  state_q    <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                end else if (parityBad_q) begin
                  rxPerror_q <= 1'b1;
                  state_q    <= IDLE;
`endif
                end else begin
                  rxData_q  <= shiftReg_q;
                  rxValid_q <= 1'b1;
                  state_q   <= IDLE;
                end
              end
            end
          end
          // A held-low line (break) must not retrigger start detection.
          WAIT_HIGH: begin
            if (lineSync) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign Rx_DATA   = rxData_q;
  assign Rx_VALID  = rxValid_q;
  assign Rx_FERROR = rxFerror_q;
  assign Rx_BUSY   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign Rx_PERROR = rxPerror_q;
`else
  assign Rx_PERROR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver. The clock is 3.6864 MHz so the divisors
// are small: 115200 -> 2, 19200 -> 12, 9600 -> 24 clocks per tick.
// Follows UART_RX_PARITY_EN to choose 8N1 or 8E1 frames.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CLK_FREQ = 3_686_400;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = 168;
  localparam int FRAME_BITS  = 11;
`else
  localparam int FRAME_TICKS = 152;
  localparam int FRAME_BITS  = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;
  logic       Rx_BUSY;

  uart_receiver #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .RxD         (RxD),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_BUSY     (Rx_BUSY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int validCount = 0;
  int ferrCount = 0;
  int perrCount = 0;
  int multiCount = 0;
  int validCycle = 0;
  int startCycle = 0;
  int bitClk = 32;
  int tickDiv = 2;
  logic [7:0] lastData = 8'h00;
  logic [7:0] rxLog[$];
  logic busyDropped = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Strobe monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (Rx_VALID === 1'b1) begin
      validCount++;
      validCycle = cycle;
      lastData = Rx_DATA;
      rxLog.push_back(Rx_DATA);
    end
    if (Rx_FERROR === 1'b1) ferrCount++;
    if (Rx_PERROR === 1'b1) perrCount++;
    if ((int'(Rx_VALID === 1'b1) + int'(Rx_FERROR === 1'b1) + int'(Rx_PERROR === 1'b1)) > 1)
      multiCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic evenParity(input logic [7:0] d);
    return ^d;
  endfunction

  // Drive one bit for a full bit period; note whether BUSY was low mid-bit.
  task automatic driveBit(input logic v, input int clocks);
    RxD = v;
    repeat (clocks / 2) @(negedge clk);
    if (Rx_BUSY !== 1'b1) busyDropped = 1'b1;
    repeat (clocks - clocks / 2) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic parityBit,
                               input logic stopBit);
    startCycle = cycle;
    busyDropped = 1'b0;
    driveBit(1'b0, bitClk);
    for (int i = 0; i < 8; i++) driveBit(data[i], bitClk);
`ifdef UART_RX_PARITY_EN
    driveBit(parityBit, bitClk);
`else
    if (parityBit === 1'bx) busyDropped = 1'b1;
`endif
    driveBit(stopBit, bitClk);
  endtask

  task automatic setBaud(input logic [2:0] sel, input int div);
    baud_select = sel;
    tickDiv = div;
    bitClk = 16 * div;
  endtask

  int v0, f0, p0, n0, diff, expLat;
  logic [7:0] expData;

  initial begin
    reset = 1'b0;
    Rx_EN = 1'b0;
    RxD = 1'b1;
    baud_select = 3'b111;
    repeat (4) @(negedge clk);
    checkOutput("reset_data", 32'(Rx_DATA), 32'h00);
    checkOutput("reset_valid", 32'(Rx_VALID), 32'h0);
    checkOutput("reset_ferror", 32'(Rx_FERROR), 32'h0);
    checkOutput("reset_perror", 32'(Rx_PERROR), 32'h0);
    checkOutput("reset_busy", 32'(Rx_BUSY), 32'h0);
    reset = 1'b1;
    Rx_EN = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_busy", 32'(Rx_BUSY), 32'h0);

    // Good byte at 115200
    $display("[TB] good byte 0x9D at 115200");
    setBaud(3'b111, 2);
    v0 = validCount; f0 = ferrCount; p0 = perrCount;
    applyStimulus(8'h9D, evenParity(8'h9D), 1'b1);
    checkOutput("good_busy_high", 32'(busyDropped), 32'h0);
    repeat (bitClk) @(negedge clk);
    checkOutput("good_valid_count", 32'(validCount - v0), 32'd1);
    checkOutput("good_data", 32'(Rx_DATA), 32'h9D);
    checkOutput("good_strobe_data", 32'(lastData), 32'h9D);
    checkOutput("good_no_errors", 32'((ferrCount - f0) + (perrCount - p0)), 32'd0);
    diff = validCycle - startCycle;
    expLat = 3 + FRAME_TICKS * tickDiv;
    checkOutput("good_latency", 32'(diff >= expLat - tickDiv && diff <= expLat + tickDiv), 32'd1);
    checkOutput("good_busy_after", 32'(Rx_BUSY), 32'h0);

    // Back-to-back at 9600
    $display("[TB] back-to-back 0x9D 0xB1 at 9600");
    setBaud(3'b011, 24);
    v0 = validCount; f0 = ferrCount; p0 = perrCount; n0 = rxLog.size();
    applyStimulus(8'h9D, evenParity(8'h9D), 1'b1);
    applyStimulus(8'hB1, evenParity(8'hB1), 1'b1);
    repeat (bitClk) @(negedge clk);
    checkOutput("b2b_valid_count", 32'(validCount - v0), 32'd2);
    checkOutput("b2b_first", 32'(rxLog.size() > n0 ? rxLog[n0] : 8'hxx), 32'h9D);
    checkOutput("b2b_second", 32'(rxLog.size() > n0 + 1 ? rxLog[n0 + 1] : 8'hxx), 32'hB1);
    checkOutput("b2b_no_errors", 32'((ferrCount - f0) + (perrCount - p0)), 32'd0);

    // Glitch: low for 5 ticks at 19200
    $display("[TB] glitch at 19200");
    setBaud(3'b100, 12);
    v0 = validCount; f0 = ferrCount; p0 = perrCount;
    RxD = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("glitch_busy_during", 32'(Rx_BUSY), 32'h1);
    repeat (5 * 12 - 40) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * bitClk) @(negedge clk);
    checkOutput("glitch_busy_after", 32'(Rx_BUSY), 32'h0);
    checkOutput("glitch_no_strobes", 32'((validCount - v0) + (ferrCount - f0) + (perrCount - p0)), 32'd0);
    checkOutput("glitch_data_held", 32'(Rx_DATA), 32'hB1);

    // Framing error followed by a break
    $display("[TB] framing error and break at 115200");
    setBaud(3'b111, 2);
    v0 = validCount; f0 = ferrCount; p0 = perrCount;
    applyStimulus(8'h3C, evenParity(8'h3C), 1'b0);
    RxD = 1'b0;
    repeat (3 * FRAME_BITS * bitClk) @(negedge clk);
    checkOutput("break_busy_held", 32'(Rx_BUSY), 32'h1);
    RxD = 1'b1;
    repeat (2 * bitClk) @(negedge clk);
    checkOutput("break_ferror_count", 32'(ferrCount - f0), 32'd1);
    checkOutput("break_no_valid", 32'(validCount - v0), 32'd0);
    checkOutput("break_no_perror", 32'(perrCount - p0), 32'd0);
    checkOutput("break_data_held", 32'(Rx_DATA), 32'hB1);
    checkOutput("break_busy_after", 32'(Rx_BUSY), 32'h0);
    v0 = validCount;
    applyStimulus(8'h55, evenParity(8'h55), 1'b1);
    repeat (bitClk) @(negedge clk);
    checkOutput("recover_valid", 32'(validCount - v0), 32'd1);
    checkOutput("recover_data", 32'(Rx_DATA), 32'h55);
    expData = 8'h55;

`ifdef UART_RX_PARITY_EN
    // Parity: 0x9D has five ones, so even parity bit is 1
    $display("[TB] parity checks");
    v0 = validCount; f0 = ferrCount; p0 = perrCount;
    applyStimulus(8'h9D, 1'b0, 1'b1);
    repeat (bitClk) @(negedge clk);
    checkOutput("parity_bad_perror", 32'(perrCount - p0), 32'd1);
    checkOutput("parity_bad_no_valid", 32'(validCount - v0), 32'd0);
    checkOutput("parity_bad_no_ferror", 32'(ferrCount - f0), 32'd0);
    checkOutput("parity_bad_data_held", 32'(Rx_DATA), 32'h55);
    v0 = validCount; p0 = perrCount;
    applyStimulus(8'h9D, 1'b1, 1'b1);
    repeat (bitClk) @(negedge clk);
    checkOutput("parity_good_valid", 32'(validCount - v0), 32'd1);
    checkOutput("parity_good_no_perror", 32'(perrCount - p0), 32'd0);
    checkOutput("parity_good_data", 32'(Rx_DATA), 32'h9D);
    expData = 8'h9D;
`endif

    // Abort by dropping Rx_EN after data bit 3
    $display("[TB] abort by Rx_EN");
    v0 = validCount; f0 = ferrCount; p0 = perrCount;
    driveBit(1'b0, bitClk);
    driveBit(1'b1, bitClk);
    driveBit(1'b1, bitClk);
    driveBit(1'b0, bitClk);
    driveBit(1'b0, bitClk);
    checkOutput("abort_en_busy_before", 32'(Rx_BUSY), 32'h1);
    Rx_EN = 1'b0;
    RxD = 1'b1;
    @(negedge clk);
    checkOutput("abort_en_busy_after", 32'(Rx_BUSY), 32'h0);
    repeat (12 * bitClk) @(negedge clk);
    Rx_EN = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abort_en_no_strobes", 32'((validCount - v0) + (ferrCount - f0) + (perrCount - p0)), 32'd0);
    checkOutput("abort_en_data_held", 32'(Rx_DATA), 32'(expData));
    v0 = validCount;
    applyStimulus(8'hA5, evenParity(8'hA5), 1'b1);
    repeat (bitClk) @(negedge clk);
    checkOutput("abort_en_next_valid", 32'(validCount - v0), 32'd1);
    checkOutput("abort_en_next_data", 32'(Rx_DATA), 32'hA5);

    // Abort by reset after data bit 5
    $display("[TB] abort by reset");
    v0 = validCount; f0 = ferrCount; p0 = perrCount;
    driveBit(1'b0, bitClk);
    for (int i = 0; i < 6; i++) driveBit(i[0], bitClk);
    checkOutput("abort_rst_busy_before", 32'(Rx_BUSY), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("abort_rst_busy_now", 32'(Rx_BUSY), 32'h0);
    checkOutput("abort_rst_data_now", 32'(Rx_DATA), 32'h00);
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    reset = 1'b1;
    repeat (2 * bitClk) @(negedge clk);
    checkOutput("abort_rst_no_strobes", 32'((validCount - v0) + (ferrCount - f0) + (perrCount - p0)), 32'd0);
    checkOutput("abort_rst_data_zero", 32'(Rx_DATA), 32'h00);
    v0 = validCount;
    applyStimulus(8'hA5, evenParity(8'hA5), 1'b1);
    repeat (bitClk) @(negedge clk);
    checkOutput("abort_rst_next_valid", 32'(validCount - v0), 32'd1);
    checkOutput("abort_rst_next_data", 32'(Rx_DATA), 32'hA5);

    checkOutput("strobes_exclusive", 32'(multiCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
